sal_ref_ctrl: RTL and testbench
===============================

Name: sal_ref_ctrl

Overview:
- Per-channel auto-refresh generator that sits directly upstream of the per-bank controllers and drives their per-bank refresh request inputs.
- Counts tREFI intervals and accumulates owed refreshes (debt) in a saturating counter.
- Requests refresh from all banks, collects per-bank grants, then holds off for tRFC before the next refresh round.

Parameters:
- NUM_BANKS, 4, number of bank controllers served (one req/gnt pair each).
- MAX_DEBT, 8, maximum owed refreshes held; 1..15.
- TREFI_W, 16, width of the tREFI value input.
- TRFC_W, 8, width of the tRFC value input.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-high.
- ref_en_i  input  1  1 = refresh timer runs; 0 = timer frozen.
- trefi_i  input  TREFI_W  refresh interval in cycles; quasi-static.
- trfc_i  input  TRFC_W  refresh recovery in cycles; quasi-static.
- idle_i  input  1  no outstanding read/write traffic in the channel (used only with the optional feature).
- ref_gnt_i  input  NUM_BANKS  per-bank refresh grant pulse from each bank controller.
- ref_req_o  output  NUM_BANKS  per-bank refresh request, level.
- ref_busy_o  output  1  FSM not in IDLE.
- ref_debt_o  output  4  current owed-refresh count.
- ref_ovf_o  output  1  sticky: a tREFI expiry occurred while debt == MAX_DEBT.

Behaviour:
- Reset (asynchronous, rst=1) clears everything:
  - ref_req_o=0, ref_busy_o=0, ref_debt_o=0, ref_ovf_o=0.
  - FSM=IDLE; refi_cnt=trefi_i-1 (sampled when rst deasserts); rfc_cnt=0; pend_mask=0.
- Timer:
  - While ref_en_i=1, refi_cnt decrements every cycle.
  - At 0 it reloads trefi_i-1 and produces a one-cycle tick.
  - While ref_en_i=0, refi_cnt holds its value and no tick occurs.
  - trefi_i=0 is treated as 1, i.e. a tick every cycle.
- Debt:
  - tick only: debt+1, saturating at MAX_DEBT. A tick at saturation sets ref_ovf_o, which clears only on reset.
  - round completion only: debt-1.
  - tick and completion in the same cycle: debt unchanged, no ovf.
- FSM states IDLE, REQ, RFC:
  - IDLE -> REQ when the start condition holds (see Optional Feature). On entry, pend_mask <= all ones.
  - REQ:
    - ref_req_o = pend_mask.
    - Bit b clears on the cycle after ref_gnt_i[b]=1 while pend_mask[b]=1. Grants for already-cleared bits are ignored.
    - Multiple grants in one cycle clear together.
    - When the masked grants cover all remaining bits: next state RFC, debt decrement, rfc_cnt <= max(trfc_i,1).
  - RFC:
    - ref_req_o=0; rfc_cnt decrements each cycle.
    - When rfc_cnt==1, next state IDLE. The RFC dwell is exactly max(trfc_i,1) cycles.
  - ref_busy_o=1 in REQ and RFC.
- Latency: IDLE with start condition true -> ref_req_o all-ones on the next cycle. The last grant -> ref_req_o=0 on the next cycle.
- ref_en_i going to 0 mid-round does not abort REQ/RFC; the round completes normally.
- ref_debt_o, ref_req_o and ref_busy_o are registered outputs.

Optional Feature:
- Macro SAL_REF_POSTPONE_EN.
- Defined (postponed/opportunistic refresh): IDLE -> REQ when debt==MAX_DEBT, or when debt>0 and idle_i=1.
- Undefined: IDLE -> REQ whenever debt>0; idle_i is ignored.
- Timer, debt and ovf rules are identical in both builds.

Test Plan:
- Basic round, macro undefined, trefi_i=10, trfc_i=5, NUM_BANKS=4, all banks grant 2 cycles after request rises:
  - first tick 10 cycles after reset release;
  - ref_req_o=4'hF for 2 cycles then 0;
  - ref_busy_o high through 5 RFC cycles;
  - debt 0->1->0.
- Staggered grants: gnt bank0 at t, bank2 at t+3, banks1+3 together at t+5 -> ref_req_o goes F, E, A, 0 on cycles t+1, t+4, t+6. A repeated gnt to bank0 at t+2 has no effect.
- Saturation, macro undefined, banks never grant, trefi_i=4, MAX_DEBT=8:
  - debt reaches 8 after 8 ticks;
  - the 9th tick sets ref_ovf_o=1 and debt stays 8;
  - a later grant of all banks gives debt=7 while ref_ovf_o stays 1.
- Simultaneous tick and completion: arrange the final grant on the tick cycle with debt=2 -> debt remains 2 and ref_ovf_o=0.
- SAL_REF_POSTPONE_EN defined, idle_i=0, trefi_i=4:
  - no request until debt==8, then ref_req_o=F;
  - separate run: debt=3 and idle_i rises -> request on the next cycle.
- Reset and enable:
  - assert rst during RFC -> all outputs 0 immediately (asynchronous), FSM IDLE after release.
  - ref_en_i=0 for 20 cycles with trefi_i=10 -> no tick, debt unchanged, and the timer resumes from its held value.

Source files
------------

// File: rtl/sal_ref_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sal_ref_ctrl
// Description : Per-channel auto-refresh generator. Counts tREFI intervals,
//               keeps a saturating count of owed refreshes (debt), asks every
//               bank controller for a refresh, collects the per-bank grants,
//               then waits tRFC before the next refresh round may start.
//
// Ports       : clk         clock
//               rst         asynchronous active-high reset
//               ref_en_i    1 = refresh interval timer runs, 0 = frozen
//               trefi_i     refresh interval in cycles (0 behaves as 1)
//               trfc_i      refresh recovery in cycles (0 behaves as 1)
//               idle_i      channel has no outstanding traffic
//               ref_gnt_i   per-bank refresh grant pulses
//               ref_req_o   per-bank refresh request levels
//               ref_busy_o  a refresh round is in progress
//               ref_debt_o  current owed-refresh count
//               ref_ovf_o   sticky: interval expired with debt already full
//
// Build macro : SAL_REF_POSTPONE_EN
//               defined   - opportunistic refresh: start a round when the
//                           debt is full, or when debt > 0 and idle_i = 1
//               undefined - start a round whenever debt > 0 (idle_i unused)
//
// Revision    : 1.0 - initial release
// ============================================================================
module sal_ref_ctrl #(
    parameter int NUM_BANKS = 4,
    parameter int MAX_DEBT  = 8,
    parameter int TREFI_W   = 16,
    parameter int TRFC_W    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ref_en_i,
    input  logic [TREFI_W-1:0]   trefi_i,
    input  logic [TRFC_W-1:0]    trfc_i,
    input  logic                 idle_i,
    input  logic [NUM_BANKS-1:0] ref_gnt_i,
    output logic [NUM_BANKS-1:0] ref_req_o,
    output logic                 ref_busy_o,
    output logic [3:0]           ref_debt_o,
    output logic                 ref_ovf_o
);

    localparam logic [3:0] DEBT_MAX = 4'(MAX_DEBT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RFC  = 2'd2
    } state_t;

    state_t               state_q;
    logic [TREFI_W-1:0]   refi_cnt_q;
    logic [TREFI_W-1:0]   refi_cnt_d;
    logic [TREFI_W-1:0]   refi_reload;
    logic [TRFC_W-1:0]    rfc_cnt_q;
    logic [TRFC_W-1:0]    rfc_load;
    logic [NUM_BANKS-1:0] pend_q;
    logic [NUM_BANKS-1:0] pend_left;
    logic [3:0]           debt_q;
    logic [3:0]           debt_d;
    logic                 ovf_q;
    logic                 ovf_d;
    logic                 tick;
    logic                 round_done;
    logic                 start;

    // ------------------------------------------------------------------
    // Interval timer: counts down trefi-1 .. 0, ticks on 0 and reloads.
    // A zero interval reloads 0, giving a tick on every enabled cycle.
    // ------------------------------------------------------------------
    always_comb begin
        refi_reload = (trefi_i == '0) ? '0 : (trefi_i - TREFI_W'(1));
        tick        = ref_en_i && (refi_cnt_q == '0);
        refi_cnt_d  = refi_cnt_q;
        if (ref_en_i) begin
            refi_cnt_d = tick ? refi_reload : (refi_cnt_q - TREFI_W'(1));
        end
    end

    // ------------------------------------------------------------------
    // Round bookkeeping
    // ------------------------------------------------------------------
    always_comb begin
        // Grants only matter for banks still pending; stale grants drop out.
        pend_left  = pend_q & ~ref_gnt_i;
        round_done = (state_q == ST_REQ) && (pend_left == '0);
        rfc_load   = (trfc_i == '0) ? TRFC_W'(1) : trfc_i;
    end

`ifdef SAL_REF_POSTPONE_EN
    // Defer refresh while traffic is flowing unless the debt is full.
    always_comb begin
        start = (debt_q == DEBT_MAX) || ((debt_q != 4'd0) && idle_i);
    end
`else
    logic unused_idle;
    assign unused_idle = idle_i;

    always_comb begin
        start = (debt_q != 4'd0);
    end
`endif

    // ------------------------------------------------------------------
    // Debt: a tick and a round completion in the same cycle cancel out.
    // ------------------------------------------------------------------
    always_comb begin
        debt_d = debt_q;
        ovf_d  = ovf_q;
        if (tick && !round_done) begin
            if (debt_q == DEBT_MAX) begin
                ovf_d = 1'b1;
            end else begin
                debt_d = debt_q + 4'd1;
            end
        end else if (round_done && !tick) begin
            debt_d = debt_q - 4'd1;
        end
    end

    // The timer restarts from the interval presented while reset is held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            refi_cnt_q <= refi_reload;
            debt_q     <= 4'd0;
            ovf_q      <= 1'b0;
        end else begin
            refi_cnt_q <= refi_cnt_d;
            debt_q     <= debt_d;
            ovf_q      <= ovf_d;
        end
    end

    // ------------------------------------------------------------------
    // Refresh round FSM with registered request/busy outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            pend_q     <= '0;
            rfc_cnt_q  <= '0;
            ref_req_o  <= '0;
            ref_busy_o <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q    <= ST_REQ;
                        pend_q     <= '1;
                        ref_req_o  <= '1;
                        ref_busy_o <= 1'b1;
                    end
                end
                ST_REQ: begin
                    pend_q <= pend_left;
                    if (pend_left == '0) begin
                        state_q   <= ST_RFC;
                        rfc_cnt_q <= rfc_load;
                        ref_req_o <= '0;
                    end else begin
                        ref_req_o <= pend_left;
                    end
                end
                ST_RFC: begin
                    rfc_cnt_q <= rfc_cnt_q - TRFC_W'(1);
                    // rfc_cnt_q is never loaded below 1; <= guards a bad value.
                    if (rfc_cnt_q <= TRFC_W'(1)) begin
                        state_q    <= ST_IDLE;
                        ref_busy_o <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    ref_req_o  <= '0;
                    ref_busy_o <= 1'b0;
                end
            endcase
        end
    end

    assign ref_debt_o = debt_q;
    assign ref_ovf_o  = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_sal_ref_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sal_ref_ctrl
// Description : Self-checking bench for sal_ref_ctrl. Directed vector table
//               for a basic round, hand-written corner sequences, and
//               randomized traffic against a behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sal_ref_ctrl;

    localparam int NB   = 4;
    localparam int MAXD = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ref_en_i = 1'b1;
    logic [15:0] trefi_i = 16'd10;
    logic [7:0]  trfc_i = 8'd5;
    logic        idle_i = 1'b1;
    logic [3:0]  ref_gnt_i = 4'h0;
    logic [3:0]  ref_req_o;
    logic        ref_busy_o;
    logic [3:0]  ref_debt_o;
    logic        ref_ovf_o;

    int checks   = 0;
    int failures = 0;

    sal_ref_ctrl #(.NUM_BANKS(NB), .MAX_DEBT(MAXD), .TREFI_W(16), .TRFC_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .ref_en_i   (ref_en_i),
        .trefi_i    (trefi_i),
        .trfc_i     (trfc_i),
        .idle_i     (idle_i),
        .ref_gnt_i  (ref_gnt_i),
        .ref_req_o  (ref_req_o),
        .ref_busy_o (ref_busy_o),
        .ref_debt_o (ref_debt_o),
        .ref_ovf_o  (ref_ovf_o)
    );

    always #5 clk = ~clk;

    // ---------------- reference model (behavioural) ----------------
    int       m_period, m_elapsed, m_debt, m_ovf, m_phase, m_rfc_left, m_trfc;
    bit [3:0] m_pend;

    task automatic model_init(input int trefi, input int trfc);
        m_period  = (trefi == 0) ? 1 : trefi;
        m_trfc    = trfc;
        m_elapsed = 0;
        m_debt    = 0;
        m_ovf     = 0;
        m_phase   = 0;
        m_rfc_left = 0;
        m_pend    = 4'h0;
    endtask

    // One clock of behaviour: phase 0 = waiting, 1 = requesting, 2 = recovery.
    task automatic model_step(input bit en, input bit [3:0] gnt, input bit idl);
        bit tick, done, start;
        tick = 1'b0;
        if (en) begin
            m_elapsed++;
            if (m_elapsed == m_period) begin
                tick = 1'b1;
                m_elapsed = 0;
            end
        end
        done = (m_phase == 1) && ((m_pend & ~gnt) == 4'h0);
`ifdef SAL_REF_POSTPONE_EN
        start = (m_debt == MAXD) || (m_debt > 0 && idl);
`else
        start = (m_debt > 0);
`endif
        if (tick && !done) begin
            if (m_debt == MAXD) m_ovf = 1;
            else m_debt++;
        end else if (done && !tick) begin
            m_debt--;
        end
        case (m_phase)
            0: if (start) begin m_phase = 1; m_pend = 4'hF; end
            1: begin
                m_pend = m_pend & ~gnt;
                if (m_pend == 4'h0) begin
                    m_phase = 2;
                    m_rfc_left = (m_trfc == 0) ? 1 : m_trfc;
                end
            end
            default: begin
                m_rfc_left--;
                if (m_rfc_left == 0) m_phase = 0;
            end
        endcase
    endtask

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive inputs for one cycle, advance the model, compare after the edge.
    task automatic cycle(input bit en, input logic [3:0] gnt, input bit idl);
        logic [9:0] exp;
        ref_en_i  = en;
        ref_gnt_i = gnt;
        idle_i    = idl;
        model_step(en, gnt, idl);
        @(posedge clk);
        #1;
        exp = {((m_phase == 1) ? m_pend : 4'h0), (m_phase != 0), 4'(m_debt), m_ovf[0]};
        chk("model", {22'd0, ref_req_o, ref_busy_o, ref_debt_o, ref_ovf_o}, {22'd0, exp});
    endtask

    task automatic release_rst();
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_init(int'(trefi_i), int'(trfc_i));
    endtask

    task automatic do_reset(input int trefi, input int trfc);
        rst       = 1'b1;
        trefi_i   = 16'(trefi);
        trfc_i    = 8'(trfc);
        ref_gnt_i = 4'h0;
        ref_en_i  = 1'b1;
        @(posedge clk);
        release_rst();
        chk("reset_state", {ref_req_o, ref_busy_o, ref_debt_o, ref_ovf_o}, 32'd0);
    endtask

    typedef struct {
        logic [3:0] gnt;
        logic [3:0] req;
        logic       busy;
        logic [3:0] debt;
    } vec_t;

    vec_t       tbl[21];
    logic [3:0] sg_gnt[6];
    logic [3:0] sg_req[6];

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Basic round, trefi=10, trfc=5; entry i describes clock edge i+1.
        for (int i = 0; i < 21; i++) tbl[i] = '{4'h0, 4'h0, 1'b0, 4'h0};
        tbl[9].debt = 4'd1;
        tbl[10] = '{4'h0, 4'hF, 1'b1, 4'd1};
        tbl[11] = '{4'h0, 4'hF, 1'b1, 4'd1};
        tbl[12] = '{4'hF, 4'h0, 1'b1, 4'd0};
        for (int i = 13; i < 17; i++) tbl[i].busy = 1'b1;
        tbl[19].debt = 4'd1;
        tbl[20] = '{4'h0, 4'hF, 1'b1, 4'd1};
        // Staggered grants: bank0, idle, bank0 again, bank2, idle, banks1+3.
        sg_gnt = '{4'h1, 4'h0, 4'h1, 4'h4, 4'h0, 4'hA};
        sg_req = '{4'hE, 4'hE, 4'hE, 4'hA, 4'hA, 4'h0};

        // ---- table-driven basic round ----
        do_reset(10, 5);
        for (int i = 0; i < 21; i++) begin
            cycle(1'b1, tbl[i].gnt, 1'b1);
            chk($sformatf("tbl_req_%0d", i + 1), {28'd0, ref_req_o}, {28'd0, tbl[i].req});
            chk($sformatf("tbl_busy_%0d", i + 1), {31'd0, ref_busy_o}, {31'd0, tbl[i].busy});
            chk($sformatf("tbl_debt_%0d", i + 1), {28'd0, ref_debt_o}, {28'd0, tbl[i].debt});
        end
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, sg_gnt[i], 1'b1);
            chk($sformatf("stagger_req_%0d", i), {28'd0, ref_req_o}, {28'd0, sg_req[i]});
        end
        chk("stagger_debt", {28'd0, ref_debt_o}, 32'd0);

        // ---- saturation, banks silent until the end ----
        do_reset(4, 5);
        for (int i = 0; i < 32; i++) cycle(1'b1, 4'h0, 1'b0);
        chk("sat_debt8", {28'd0, ref_debt_o}, 32'd8);
        chk("sat_no_ovf", {31'd0, ref_ovf_o}, 32'd0);
`ifdef SAL_REF_POSTPONE_EN
        chk("postpone_no_req", {28'd0, ref_req_o}, 32'h0);
`else
        chk("sat_req", {28'd0, ref_req_o}, 32'hF);
`endif
        cycle(1'b1, 4'h0, 1'b0);
        chk("sat_req_full", {28'd0, ref_req_o}, 32'hF);
        for (int i = 0; i < 3; i++) cycle(1'b1, 4'h0, 1'b0);
        chk("sat_ovf_set", {31'd0, ref_ovf_o}, 32'd1);
        chk("sat_debt_hold", {28'd0, ref_debt_o}, 32'd8);
        cycle(1'b1, 4'hF, 1'b0);
        chk("sat_debt_dec", {28'd0, ref_debt_o}, 32'd7);
        chk("sat_ovf_sticky", {31'd0, ref_ovf_o}, 32'd1);

        // ---- tick and completion on the same cycle ----
        do_reset(4, 5);
        for (int i = 0; i < 11; i++) cycle(1'b1, 4'h0, 1'b1);
        chk("simul_pre_debt", {28'd0, ref_debt_o}, 32'd2);
        cycle(1'b1, 4'hF, 1'b1);
        chk("simul_debt", {28'd0, ref_debt_o}, 32'd2);
        chk("simul_ovf", {31'd0, ref_ovf_o}, 32'd0);
        chk("simul_req", {28'd0, ref_req_o}, 32'h0);

`ifdef SAL_REF_POSTPONE_EN
        // ---- opportunistic start once the channel goes idle ----
        do_reset(4, 5);
        for (int i = 0; i < 12; i++) cycle(1'b1, 4'h0, 1'b0);
        chk("pp_debt3", {28'd0, ref_debt_o}, 32'd3);
        chk("pp_wait", {28'd0, ref_req_o}, 32'h0);
        cycle(1'b1, 4'h0, 1'b1);
        chk("pp_idle_req", {28'd0, ref_req_o}, 32'hF);
`endif

        // ---- asynchronous reset during recovery ----
        do_reset(2, 8);
        for (int i = 0; i < 8; i++) cycle(1'b1, 4'h0, 1'b1);
        cycle(1'b1, 4'hF, 1'b1);
        cycle(1'b1, 4'h0, 1'b1);
        chk("pre_rst_busy", {31'd0, ref_busy_o}, 32'd1);
        chk("pre_rst_debt", {28'd0, ref_debt_o}, 32'd4);
        #3 rst = 1'b1;
        #1;
        chk("async_rst", {ref_req_o, ref_busy_o, ref_debt_o, ref_ovf_o}, 32'd0);
        release_rst();
        cycle(1'b1, 4'h0, 1'b0);
        chk("post_rst_idle", {31'd0, ref_busy_o}, 32'd0);

        // ---- timer freeze and resume ----
        do_reset(10, 5);
        for (int i = 0; i < 5; i++) cycle(1'b1, 4'h0, 1'b1);
        for (int i = 0; i < 20; i++) cycle(1'b0, 4'h0, 1'b1);
        chk("freeze_debt", {28'd0, ref_debt_o}, 32'd0);
        for (int i = 0; i < 4; i++) cycle(1'b1, 4'h0, 1'b1);
        chk("resume_no_tick", {28'd0, ref_debt_o}, 32'd0);
        cycle(1'b1, 4'h0, 1'b1);
        chk("resume_tick", {28'd0, ref_debt_o}, 32'd1);

        // ---- randomized traffic against the model ----
        for (int run = 0; run < 4; run++) begin
            do_reset(int'($urandom_range(0, 6)), int'($urandom_range(0, 5)));
            for (int i = 0; i < 300; i++) begin
                cycle(($urandom_range(0, 7) != 0), 4'($urandom & $urandom),
                      ($urandom_range(0, 2) == 0));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
